// File: rtl/mult_check_pkg.sv
// rtl/mult_check_pkg.sv - shared types, defaults and saturation helper for the multiplier result checker
package mult_check_pkg;

  localparam int DEFAULT_WIDTH = 1024;
  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    COMPARE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/mult_capture_lane.sv
// rtl/mult_capture_lane.sv - one lane: saturating latency counter plus single-shot product capture
module mult_capture_lane
  import mult_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 done,
  input  logic                 force_cap,
  input  logic [2*WIDTH-1:0]   product,
  output logic [CNT_W-1:0]     cycles,
  output logic                 captured,
  output logic                 forced,
  output logic [2*WIDTH-1:0]   value
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  // A real done wins over a forced capture when both land on the saturated cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycles   <= '0;
      captured <= 1'b0;
      forced   <= 1'b0;
      value    <= '0;
    end else if (enable && !captured) begin
      if (done) begin
        value    <= product;
        captured <= 1'b1;
      end else if (force_cap) begin
        value    <= '0;
        captured <= 1'b1;
        forced   <= 1'b1;
      end else if (cycles != CNT_MAX) begin
        cycles <= cycles + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_result_checker.sv
// rtl/mult_result_checker.sv - compares latency and product of two multipliers sharing one start
module mult_result_checker
  import mult_check_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*WIDTH-1:0]   productA,
  input  logic                 productDoneA,
  input  logic [2*WIDTH-1:0]   productB,
  input  logic                 productDoneB,
  output logic [CNT_W-1:0]     cyclesA,
  output logic [CNT_W-1:0]     cyclesB,
  output logic                 timingLeak,
  output logic                 timingLeakDone,
  output logic                 productMismatch,
  output logic                 timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

  state_t state;
  logic arm, run_en;
  logic force_a, force_b, cap_a, cap_b, forced_a, forced_b, fin_a, fin_b;
  logic [2*WIDTH-1:0] value_a, value_b;

  assign arm     = start && (state == IDLE || state == HOLD);
  assign run_en  = (state == RUN);
  assign force_a = (cyclesA == CNT_MAX);
  assign force_b = (cyclesB == CNT_MAX);
  // Lane is finished this cycle if already captured or about to capture on this edge.
  assign fin_a   = cap_a || productDoneA || force_a;
  assign fin_b   = cap_b || productDoneB || force_b;

  mult_capture_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) lane_a (
    .clk(clk), .rst(rst), .clear(arm), .enable(run_en), .done(productDoneA),
    .force_cap(force_a), .product(productA), .cycles(cyclesA), .captured(cap_a),
    .forced(forced_a), .value(value_a)
  );

  mult_capture_lane #(.WIDTH(WIDTH), .CNT_W(CNT_W)) lane_b (
    .clk(clk), .rst(rst), .clear(arm), .enable(run_en), .done(productDoneB),
    .force_cap(force_b), .product(productB), .cycles(cyclesB), .captured(cap_b),
    .forced(forced_b), .value(value_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timingLeak      <= 1'b0;
      timingLeakDone  <= 1'b0;
      productMismatch <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (start) begin
            timingLeak      <= 1'b0;
            timingLeakDone  <= 1'b0;
            productMismatch <= 1'b0;
            timeout         <= 1'b0;
            state           <= RUN;
          end else if (state == HOLD) begin
            timingLeakDone <= 1'b1;
          end
        end
        RUN: begin
          if (fin_a && fin_b) state <= COMPARE;
        end
        COMPARE: begin
          timeout         <= forced_a || forced_b;
          timingLeak      <= (cyclesA != cyclesB) || forced_a || forced_b;
          productMismatch <= (value_a != value_b);
          state           <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_result_checker.sv
// tb/tb_mult_result_checker.sv - randomized and directed self-checking bench for mult_result_checker
module tb_mult_result_checker;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int SAT   = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [2*WIDTH-1:0]   productA = '0;
  logic                 productDoneA = 1'b0;
  logic [2*WIDTH-1:0]   productB = '0;
  logic                 productDoneB = 1'b0;
  logic [CNT_W-1:0]     cyclesA, cyclesB;
  logic                 timingLeak, timingLeakDone, productMismatch, timeout;

  int total = 0;
  int bad = 0;

  mult_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .productA(productA), .productDoneA(productDoneA),
    .productB(productB), .productDoneB(productDoneB),
    .cyclesA(cyclesA), .cyclesB(cyclesB),
    .timingLeak(timingLeak), .timingLeakDone(timingLeakDone),
    .productMismatch(productMismatch), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".cyclesA"}, 32'(cyclesA), 0);
    check({tag, ".cyclesB"}, 32'(cyclesB), 0);
    check({tag, ".leak"}, 32'(timingLeak), 0);
    check({tag, ".done"}, 32'(timingLeakDone), 0);
    check({tag, ".mismatch"}, 32'(productMismatch), 0);
    check({tag, ".timeout"}, 32'(timeout), 0);
  endtask

  // la/lb: number of RUN cycles with done low before done rises; negative means never.
  task automatic run_check(input string tag, input int la, input int lb,
                           input logic [15:0] pa, input logic [15:0] pb,
                           input int hold, input bit glitch);
    bit ok_a, ok_b, exp_to, exp_leak, exp_mm;
    int ca, cb, m, last;
    logic [15:0] va, vb;
    ok_a = (la >= 0) && (la <= SAT);
    ok_b = (lb >= 0) && (lb <= SAT);
    ca = ok_a ? la : SAT;
    cb = ok_b ? lb : SAT;
    va = ok_a ? pa : 16'h0;
    vb = ok_b ? pb : 16'h0;
    exp_to   = !ok_a || !ok_b;
    exp_leak = (ca != cb) || exp_to;
    exp_mm   = (va != vb);
    m    = (ca > cb) ? ca : cb;
    last = m + 2;
    if (la >= 0 && la + hold - 1 > last) last = la + hold - 1;
    if (lb >= 0 && lb + hold - 1 > last) last = lb + hold - 1;

    productDoneA = 1'b0;
    productDoneB = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_all_zero({tag, ".armed"});

    for (int i = 0; i <= last; i++) begin
      productDoneA = (la >= 0) && (i >= la) && (i < la + hold);
      productDoneB = (lb >= 0) && (lb >= 0) && (i >= lb) && (i < lb + hold);
      productA = (i == la) ? pa : 16'($urandom);
      productB = (i == lb) ? pb : 16'($urandom);
      start = glitch && (i == 1);
      step();
      if (i == m + 1) check({tag, ".done_early"}, 32'(timingLeakDone), 0);
      if (i == m + 2) check({tag, ".done_rise"}, 32'(timingLeakDone), 1);
    end
    productDoneA = 1'b0;
    productDoneB = 1'b0;
    start = 1'b0;
    step();
    check({tag, ".cyclesA"}, 32'(cyclesA), 32'(ca));
    check({tag, ".cyclesB"}, 32'(cyclesB), 32'(cb));
    check({tag, ".leak"}, 32'(timingLeak), 32'(exp_leak));
    check({tag, ".mismatch"}, 32'(productMismatch), 32'(exp_mm));
    check({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
    check({tag, ".done_hold"}, 32'(timingLeakDone), 1);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_all_zero("reset");

    productDoneA = 1'b1;
    productDoneB = 1'b1;
    step();
    step();
    productDoneA = 1'b0;
    productDoneB = 1'b0;
    check_all_zero("idle_done");

    run_check("match", 5, 5, 16'h0F3C, 16'h0F3C, 1, 1'b0);
    run_check("leak", 3, 7, 16'h0100, 16'h0100, 1, 1'b0);
    run_check("mm_hold", 4, 4, 16'h1234, 16'h1235, 10, 1'b0);
    run_check("timeout", 2, -1, 16'h00AA, 16'h00AA, 1, 1'b0);
    run_check("sat_done", 15, 15, 16'h8001, 16'h8001, 1, 1'b0);
    run_check("same0", 0, 0, 16'hFFFF, 16'h7FFF, 1, 1'b0);
    run_check("start_run", 6, 2, 16'hAAAA, 16'hAAAA, 1, 1'b1);

    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_run");
    step();
    check_all_zero("rst_idle");

    for (int r = 0; r < 8; r++) begin
      int la, lb, hold;
      logic [15:0] pa, pb;
      la   = int'($urandom_range(0, 17));
      lb   = int'($urandom_range(0, 17));
      hold = int'($urandom_range(1, 3));
      pa   = 16'($urandom);
      pb   = ($urandom_range(0, 1) == 1) ? pa : 16'($urandom);
      run_check("random", la, lb, pa, pb, hold, 1'($urandom_range(0, 1)));
    end

    rst = 1'b1;
    step();
    rst = 1'b0;
    check_all_zero("rst_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
